// File: rtl/grf_write_port_pkg.sv
// grf_write_port_pkg: register-file widths and the hardwired-zero register address.
package grf_write_port_pkg;
    localparam int AW = 5;
    localparam int DW = 32;
    localparam logic [AW-1:0] REG_ZERO = 5'd0;
endpackage

// File: rtl/grf_write_port_if.sv
// grf_write_port_if: writeback, slow-request, register-file and bypass-lookup signals.
interface grf_write_port_if
    import grf_write_port_pkg::*;
#(
    parameter int DEPTH = 4
);
    logic                   PipeWriteEnable;
    logic [AW-1:0]          PipeWriteAddress;
    logic [DW-1:0]          PipeWriteData;
    logic                   SlowWriteValid;
    logic                   SlowWriteReady;
    logic [AW-1:0]          SlowWriteAddress;
    logic [DW-1:0]          SlowWriteData;
    logic                   WriteEnable;
    logic [AW-1:0]          WriteAddress;
    logic [DW-1:0]          WriteData;
    logic [AW-1:0]          LookupAddress1;
    logic [AW-1:0]          LookupAddress2;
    logic                   LookupHit1;
    logic                   LookupHit2;
    logic [DW-1:0]          LookupData1;
    logic [DW-1:0]          LookupData2;
    logic [$clog2(DEPTH):0] Pending;

    modport master (
        output PipeWriteEnable, PipeWriteAddress, PipeWriteData,
        output SlowWriteValid, SlowWriteAddress, SlowWriteData,
        output LookupAddress1, LookupAddress2,
        input  SlowWriteReady, WriteEnable, WriteAddress, WriteData,
        input  LookupHit1, LookupHit2, LookupData1, LookupData2, Pending
    );
    modport slave (
        input  PipeWriteEnable, PipeWriteAddress, PipeWriteData,
        input  SlowWriteValid, SlowWriteAddress, SlowWriteData,
        input  LookupAddress1, LookupAddress2,
        output SlowWriteReady, WriteEnable, WriteAddress, WriteData,
        output LookupHit1, LookupHit2, LookupData1, LookupData2, Pending
    );
endinterface

// File: rtl/grf_wb_fifo.sv
// grf_wb_fifo: circular slow-write buffer with per-entry kill bits, exposed oldest-first for arbitration and bypass.
module grf_wb_fifo
    import grf_write_port_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PW = $clog2(DEPTH)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      push,
    input  logic [AW-1:0]             push_addr,
    input  logic [DW-1:0]             push_data,
    input  logic                      pop,
    input  logic                      kill,
    input  logic [AW-1:0]             kill_addr,
    output logic [PW:0]               count,
    output logic [DEPTH-1:0][AW-1:0]  age_addr,
    output logic [DEPTH-1:0][DW-1:0]  age_data,
    output logic [DEPTH-1:0]          age_live
);
    logic [DEPTH-1:0][AW-1:0] addr_q;
    logic [DEPTH-1:0][DW-1:0] data_q;
    logic [DEPTH-1:0]         dead;
    logic [PW-1:0]            head, tail;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            dead  <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++)
                if (kill && addr_q[i] == kill_addr) dead[i] <= 1'b1;
            // the push slot is unoccupied, so clearing its kill bit here makes a same-edge push live
            if (push) begin
                addr_q[tail] <= push_addr;
                data_q[tail] <= push_data;
                dead[tail]   <= 1'b0;
                tail         <= tail + 1'b1;
            end
            if (pop) head <= head + 1'b1;
            count <= count + (PW+1)'(push) - (PW+1)'(pop);
        end
    end

    always_comb begin
        age_addr = '0;
        age_data = '0;
        age_live = '0;
        for (int i = 0; i < DEPTH; i++) begin
            age_addr[i] = addr_q[head + PW'(i)];
            age_data[i] = data_q[head + PW'(i)];
            age_live[i] = ((PW+1)'(i) < count) && !dead[head + PW'(i)];
        end
    end
endmodule

// File: rtl/grf_write_port.sv
// grf_write_port: merges pipeline and slow writebacks onto one registered register-file write port with bypass lookup.
module grf_write_port
    import grf_write_port_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input logic            clk,
    input logic            Reset,
    grf_write_port_if.slave bus
);
    localparam int PW = $clog2(DEPTH);

    logic                     pipe_go, push, pop;
    logic [PW:0]              count;
    logic [DEPTH-1:0][AW-1:0] age_addr;
    logic [DEPTH-1:0][DW-1:0] age_data;
    logic [DEPTH-1:0]         age_live;
    logic [DW:0]              look1, look2;

    assign bus.SlowWriteReady = Reset && (count < (PW+1)'(DEPTH));
    assign pipe_go = bus.PipeWriteEnable && bus.PipeWriteAddress != REG_ZERO;
    assign push    = bus.SlowWriteValid && bus.SlowWriteReady && bus.SlowWriteAddress != REG_ZERO;
    assign pop     = !pipe_go && count != '0;
    assign bus.Pending = count;

    grf_wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .rst_n     (Reset),
        .push      (push),
        .push_addr (bus.SlowWriteAddress),
        .push_data (bus.SlowWriteData),
        .pop       (pop),
        .kill      (pipe_go),
        .kill_addr (bus.PipeWriteAddress),
        .count     (count),
        .age_addr  (age_addr),
        .age_data  (age_data),
        .age_live  (age_live)
    );

    always_ff @(posedge clk) begin
        if (!Reset) begin
            bus.WriteEnable  <= 1'b0;
            bus.WriteAddress <= '0;
            bus.WriteData    <= '0;
        end else if (pipe_go) begin
            bus.WriteEnable  <= 1'b1;
            bus.WriteAddress <= bus.PipeWriteAddress;
            bus.WriteData    <= bus.PipeWriteData;
        end else begin
            bus.WriteEnable <= pop && age_live[0];
            if (pop && age_live[0]) begin
                bus.WriteAddress <= age_addr[0];
                bus.WriteData    <= age_data[0];
            end
        end
    end

    // oldest-to-youngest scan so the youngest live FIFO match overrides the output register
    always_comb begin
        look1 = {bus.WriteEnable && bus.WriteAddress == bus.LookupAddress1, bus.WriteData};
        look2 = {bus.WriteEnable && bus.WriteAddress == bus.LookupAddress2, bus.WriteData};
        for (int i = 0; i < DEPTH; i++) begin
            if (age_live[i] && age_addr[i] == bus.LookupAddress1) look1 = {1'b1, age_data[i]};
            if (age_live[i] && age_addr[i] == bus.LookupAddress2) look2 = {1'b1, age_data[i]};
        end
    end

    assign bus.LookupHit1  = look1[DW] && bus.LookupAddress1 != REG_ZERO;
    assign bus.LookupHit2  = look2[DW] && bus.LookupAddress2 != REG_ZERO;
    assign bus.LookupData1 = look1[DW-1:0];
    assign bus.LookupData2 = look2[DW-1:0];
endmodule

// File: tb/tb_grf_write_port.sv
// tb_grf_write_port: directed scenario checks of the register-file write port front end.
module tb_grf_write_port;
    logic clk = 1'b0;
    logic Reset;
    int checks = 0;
    int errors = 0;

    grf_write_port_if #(.DEPTH(4)) bus();
    grf_write_port #(.DEPTH(4)) dut (.clk(clk), .Reset(Reset), .bus(bus));

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.PipeWriteEnable = 0; bus.PipeWriteAddress = 0; bus.PipeWriteData = 0;
        bus.SlowWriteValid = 0; bus.SlowWriteAddress = 0; bus.SlowWriteData = 0;
    endtask

    task automatic test_reset();
        Reset = 0;
        idle();
        bus.PipeWriteEnable = 1; bus.PipeWriteAddress = 5; bus.PipeWriteData = 32'hFFFF;
        bus.LookupAddress1 = 5; bus.LookupAddress2 = 0;
        for (int c = 0; c < 2; c++) begin
            tick();
            checks++; if (bus.WriteEnable !== 1'b0) begin errors++; $display("FAIL rst_we got %0h exp 0", bus.WriteEnable); end
            checks++; if (bus.WriteAddress !== 5'd0) begin errors++; $display("FAIL rst_wa got %0h exp 0", bus.WriteAddress); end
            checks++; if (bus.WriteData !== 32'd0) begin errors++; $display("FAIL rst_wd got %0h exp 0", bus.WriteData); end
            checks++; if (bus.Pending !== 3'd0) begin errors++; $display("FAIL rst_pending got %0d exp 0", bus.Pending); end
            checks++; if (bus.SlowWriteReady !== 1'b0) begin errors++; $display("FAIL rst_ready got %0h exp 0", bus.SlowWriteReady); end
            checks++; if (bus.LookupHit1 !== 1'b0) begin errors++; $display("FAIL rst_hit got %0h exp 0", bus.LookupHit1); end
        end
        Reset = 1;
        idle();
        tick();
        checks++; if (bus.SlowWriteReady !== 1'b1) begin errors++; $display("FAIL rel_ready got %0h exp 1", bus.SlowWriteReady); end
        checks++; if (bus.WriteEnable !== 1'b0) begin errors++; $display("FAIL rel_we got %0h exp 0", bus.WriteEnable); end
    endtask

    task automatic test_pipe();
        bus.PipeWriteEnable = 1; bus.PipeWriteAddress = 5; bus.PipeWriteData = 32'h1234;
        tick();
        checks++; if (bus.WriteEnable !== 1'b1) begin errors++; $display("FAIL pipe_we got %0h exp 1", bus.WriteEnable); end
        checks++; if (bus.WriteAddress !== 5'd5) begin errors++; $display("FAIL pipe_wa got %0d exp 5", bus.WriteAddress); end
        checks++; if (bus.WriteData !== 32'h1234) begin errors++; $display("FAIL pipe_wd got %0h exp 1234", bus.WriteData); end
        bus.LookupAddress1 = 5; #1;
        checks++; if ({bus.LookupHit1, bus.LookupData1} !== {1'b1, 32'h1234}) begin errors++; $display("FAIL pipe_lookup got %0h/%0h exp 1/1234", bus.LookupHit1, bus.LookupData1); end
        bus.PipeWriteAddress = 0; bus.PipeWriteData = 32'hDEAD;
        bus.SlowWriteValid = 1; bus.SlowWriteAddress = 0; bus.SlowWriteData = 32'hBEEF;
        tick();
        checks++; if (bus.WriteEnable !== 1'b0) begin errors++; $display("FAIL pipe_zero_we got %0h exp 0", bus.WriteEnable); end
        checks++; if (bus.Pending !== 3'd0) begin errors++; $display("FAIL slow_zero_pending got %0d exp 0", bus.Pending); end
        idle();
    endtask

    task automatic test_back_to_back();
        for (int k = 1; k <= 4; k++) begin
            bus.PipeWriteEnable = 1; bus.PipeWriteAddress = 10; bus.PipeWriteData = 32'h100 + k;
            bus.SlowWriteValid = 1; bus.SlowWriteAddress = 5'(k); bus.SlowWriteData = 32'hA0 + k;
            tick();
            checks++; if (bus.Pending !== 3'(k)) begin errors++; $display("FAIL fill_pending got %0d exp %0d", bus.Pending, k); end
            checks++; if (bus.WriteAddress !== 5'd10 || bus.WriteData !== 32'h100 + k) begin errors++; $display("FAIL fill_out got %0d/%0h exp 10/%0h", bus.WriteAddress, bus.WriteData, 32'h100 + k); end
        end
        checks++; if (bus.SlowWriteReady !== 1'b0) begin errors++; $display("FAIL full_ready got %0h exp 0", bus.SlowWriteReady); end
        idle();
        for (int k = 1; k <= 4; k++) begin
            tick();
            checks++; if ({bus.WriteEnable, bus.WriteAddress, bus.WriteData} !== {1'b1, 5'(k), 32'hA0 + k}) begin errors++; $display("FAIL drain_%0d got %0h/%0d/%0h exp 1/%0d/%0h", k, bus.WriteEnable, bus.WriteAddress, bus.WriteData, k, 32'hA0 + k); end
            checks++; if (bus.Pending !== 3'(4 - k)) begin errors++; $display("FAIL drain_pending got %0d exp %0d", bus.Pending, 4 - k); end
            checks++; if (bus.SlowWriteReady !== 1'b1) begin errors++; $display("FAIL drain_ready got %0h exp 1", bus.SlowWriteReady); end
        end
        tick();
        checks++; if (bus.WriteEnable !== 1'b0) begin errors++; $display("FAIL drain_done_we got %0h exp 0", bus.WriteEnable); end
    endtask

    task automatic test_squash();
        bus.SlowWriteValid = 1; bus.SlowWriteAddress = 7; bus.SlowWriteData = 32'hA;
        tick();
        idle();
        bus.PipeWriteEnable = 1; bus.PipeWriteAddress = 7; bus.PipeWriteData = 32'hB;
        tick();
        idle();
        bus.LookupAddress1 = 7; #1;
        checks++; if ({bus.WriteEnable, bus.WriteAddress, bus.WriteData} !== {1'b1, 5'd7, 32'hB}) begin errors++; $display("FAIL squash_out got %0h/%0d/%0h exp 1/7/b", bus.WriteEnable, bus.WriteAddress, bus.WriteData); end
        checks++; if (bus.Pending !== 3'd1) begin errors++; $display("FAIL squash_pending got %0d exp 1", bus.Pending); end
        checks++; if ({bus.LookupHit1, bus.LookupData1} !== {1'b1, 32'hB}) begin errors++; $display("FAIL squash_lookup got %0h/%0h exp 1/b", bus.LookupHit1, bus.LookupData1); end
        tick();
        checks++; if (bus.WriteEnable !== 1'b0) begin errors++; $display("FAIL squash_pop_we got %0h exp 0", bus.WriteEnable); end
        checks++; if (bus.Pending !== 3'd0) begin errors++; $display("FAIL squash_pop_pending got %0d exp 0", bus.Pending); end
        checks++; if (bus.LookupHit1 !== 1'b0) begin errors++; $display("FAIL squash_gone_hit got %0h exp 0", bus.LookupHit1); end
        bus.PipeWriteEnable = 1; bus.PipeWriteAddress = 8; bus.PipeWriteData = 32'h1;
        bus.SlowWriteValid = 1; bus.SlowWriteAddress = 8; bus.SlowWriteData = 32'h2;
        tick();
        idle();
        bus.LookupAddress1 = 8; #1;
        checks++; if ({bus.LookupHit1, bus.LookupData1} !== {1'b1, 32'h2}) begin errors++; $display("FAIL same_cycle_lookup got %0h/%0h exp 1/2", bus.LookupHit1, bus.LookupData1); end
        tick();
        checks++; if ({bus.WriteEnable, bus.WriteAddress, bus.WriteData} !== {1'b1, 5'd8, 32'h2}) begin errors++; $display("FAIL same_cycle_issue got %0h/%0d/%0h exp 1/8/2", bus.WriteEnable, bus.WriteAddress, bus.WriteData); end
    endtask

    task automatic test_lookup();
        bus.PipeWriteEnable = 1; bus.PipeWriteAddress = 11; bus.PipeWriteData = 32'h55;
        bus.SlowWriteValid = 1; bus.SlowWriteAddress = 9; bus.SlowWriteData = 32'h1;
        tick();
        bus.PipeWriteData = 32'h66; bus.SlowWriteData = 32'h2;
        tick();
        bus.SlowWriteValid = 0;
        bus.LookupAddress1 = 9; bus.LookupAddress2 = 0; #1;
        checks++; if ({bus.LookupHit1, bus.LookupData1} !== {1'b1, 32'h2}) begin errors++; $display("FAIL lookup_young got %0h/%0h exp 1/2", bus.LookupHit1, bus.LookupData1); end
        checks++; if (bus.LookupHit2 !== 1'b0) begin errors++; $display("FAIL lookup_zero got %0h exp 0", bus.LookupHit2); end
        bus.LookupAddress2 = 11; #1;
        checks++; if ({bus.LookupHit2, bus.LookupData2} !== {1'b1, 32'h66}) begin errors++; $display("FAIL lookup_outreg got %0h/%0h exp 1/66", bus.LookupHit2, bus.LookupData2); end
        bus.LookupAddress2 = 12; #1;
        checks++; if (bus.LookupHit2 !== 1'b0) begin errors++; $display("FAIL lookup_miss got %0h exp 0", bus.LookupHit2); end
    endtask

    task automatic test_reset_mid();
        bus.PipeWriteEnable = 1; bus.PipeWriteAddress = 11; bus.PipeWriteData = 32'h77;
        bus.SlowWriteValid = 1; bus.SlowWriteAddress = 12; bus.SlowWriteData = 32'h3;
        tick();
        checks++; if (bus.Pending !== 3'd3) begin errors++; $display("FAIL mid_pending got %0d exp 3", bus.Pending); end
        idle();
        Reset = 0;
        tick();
        Reset = 1;
        checks++; if (bus.Pending !== 3'd0) begin errors++; $display("FAIL mid_rst_pending got %0d exp 0", bus.Pending); end
        checks++; if (bus.WriteEnable !== 1'b0) begin errors++; $display("FAIL mid_rst_we got %0h exp 0", bus.WriteEnable); end
        for (int c = 0; c < 4; c++) begin
            tick();
            checks++; if (bus.WriteEnable !== 1'b0 || bus.Pending !== 3'd0) begin errors++; $display("FAIL post_rst_quiet got %0h/%0d exp 0/0", bus.WriteEnable, bus.Pending); end
        end
    endtask

    initial begin
        test_reset();
        test_pipe();
        test_back_to_back();
        test_squash();
        test_lookup();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
